// File: rtl/timer_pkg.sv
// Types and widths shared by the timer capture path and the register block.
package timer_pkg;

    localparam int TIMER_DATA_W = 32;
    localparam int CAP_SEQ_W    = 8;

    typedef struct packed {
        logic [CAP_SEQ_W-1:0]    seq;
        logic [TIMER_DATA_W-1:0] val;
    } cap_entry_t;

endpackage

// File: rtl/timer_capture_fifo_ram.sv
// Capture entry storage: one synchronous write port, one asynchronous read port.
module cap_fifo_ram
    import timer_pkg::*;
#(
    parameter int  DEPTH   = 8,
    parameter type entry_t = cap_entry_t,
    parameter int  AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  entry_t        wdata,
    input  logic [AW-1:0] raddr,
    output entry_t        rdata
);

    // Contents are deliberately left unreset; only the pointers in the parent are.
    entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/timer_capture_fifo.sv
// Buffers timer capture events with a wrapping sequence tag; FWFT head, level, sticky overflow and level irq.
module timer_capture_fifo
    import timer_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = TIMER_DATA_W,
    parameter int SEQ_WIDTH  = CAP_SEQ_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr_i,
    input  logic                         cap_stb_i,
    input  logic [DATA_WIDTH-1:0]        cap_val_i,
    input  logic                         pop_i,
    output logic [DATA_WIDTH-1:0]        pop_data_o,
    output logic [SEQ_WIDTH-1:0]         pop_seq_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    input  logic [$clog2(DEPTH+1)-1:0]   thresh_i,
    output logic                         ovf_o,
    input  logic                         ovf_clr_i,
    output logic                         irq_o
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("timer_capture_fifo: DEPTH must be a power of 2 and >= 2");
    end

    typedef struct packed {
        logic [SEQ_WIDTH-1:0]  seq;
        logic [DATA_WIDTH-1:0] val;
    } entry_t;

    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [LW-1:0]        level, level_nxt;
    logic [SEQ_WIDTH-1:0] seq;
    logic                 ovf, ovf_nxt, irq, irq_nxt;
    logic                 empty, full, push_ok, pop_ok, ovf_set;
    entry_t               wr_entry, rd_entry;

    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));

    // A simultaneous pop frees a slot, so a push into a full FIFO is still accepted.
    assign pop_ok   = pop_i && !empty;
    assign push_ok  = cap_stb_i && (!full || pop_i);
    assign ovf_set  = cap_stb_i && full && !pop_i;
    assign wr_entry = '{seq: seq, val: cap_val_i};

    always_comb begin
        level_nxt = level;
        ovf_nxt   = ovf;
        irq_nxt   = 1'b0;
        if (clr_i) begin
            level_nxt = '0;
            ovf_nxt   = 1'b0;
        end else begin
            if (push_ok && !pop_ok) begin
                level_nxt = level + LW'(1);
            end else if (!push_ok && pop_ok) begin
                level_nxt = level - LW'(1);
            end
            if (ovf_set) begin
                ovf_nxt = 1'b1;
            end else if (ovf_clr_i) begin
                ovf_nxt = 1'b0;
            end
        end
        irq_nxt = ((thresh_i != '0) && (level_nxt >= thresh_i)) || ovf_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            seq    <= '0;
            ovf    <= 1'b0;
            irq    <= 1'b0;
        end else begin
            level <= level_nxt;
            ovf   <= ovf_nxt;
            irq   <= irq_nxt;
            if (clr_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                seq    <= '0;
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop_ok) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                // Dropped strobes still consume a tag so software can see the gap.
                if (cap_stb_i) begin
                    seq <= seq + SEQ_WIDTH'(1);
                end
            end
        end
    end

    cap_fifo_ram #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_ram (
        .clk   (clk),
        .we    (push_ok && !clr_i),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    assign pop_data_o = empty ? '0 : rd_entry.val;
    assign pop_seq_o  = empty ? '0 : rd_entry.seq;
    assign empty_o    = empty;
    assign full_o     = full;
    assign level_o    = level;
    assign ovf_o      = ovf;
    assign irq_o      = irq;

endmodule

// File: tb/tb_timer_capture_fifo.sv
// Scoreboard bench for timer_capture_fifo against a queue-based reference model.
module tb_timer_capture_fifo;

    localparam int DEPTH = 8;
    localparam int DW    = 32;
    localparam int SW    = 8;
    localparam int LW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          cap = 1'b0;
    logic [DW-1:0] val = '0;
    logic          pop = 1'b0;
    logic          oclr = 1'b0;
    logic [LW-1:0] thr = '0;
    logic [LW-1:0] thr_next = '0;

    logic [DW-1:0] pop_data;
    logic [SW-1:0] pop_seq;
    logic          empty, full, ovf, irq;
    logic [LW-1:0] level;

    always #5 clk = ~clk;

    timer_capture_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .SEQ_WIDTH(SW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (clr),
        .cap_stb_i  (cap),
        .cap_val_i  (val),
        .pop_i      (pop),
        .pop_data_o (pop_data),
        .pop_seq_o  (pop_seq),
        .empty_o    (empty),
        .full_o     (full),
        .level_o    (level),
        .thresh_i   (thr),
        .ovf_o      (ovf),
        .ovf_clr_i  (oclr),
        .irq_o      (irq)
    );

    typedef struct {
        logic [SW-1:0] seq;
        logic [DW-1:0] val;
    } ent_t;

    ent_t          mq[$];
    ent_t          exp_pop[$];
    ent_t          mon_e;
    logic [SW-1:0] m_seq = '0;
    bit            m_ovf = 1'b0;
    bit            m_irq = 1'b0;
    int            n_cmp = 0;
    int            n_bad = 0;
    bit            chk_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advances by one clock edge given the inputs presented to it.
    task automatic model_step(input bit c, input logic [DW-1:0] v, input bit p, input bit cl, input bit oc);
        bit   was_full, was_empty, drop;
        ent_t e;
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        drop      = 1'b0;
        if (cl) begin
            mq.delete();
            m_seq = '0;
            m_ovf = 1'b0;
        end else begin
            if (p && !was_empty) begin
                exp_pop.push_back(mq[0]);
                void'(mq.pop_front());
            end
            if (c) begin
                if (!was_full || p) begin
                    e.seq = m_seq;
                    e.val = v;
                    mq.push_back(e);
                end else begin
                    drop = 1'b1;
                end
                m_seq = m_seq + 1'b1;
            end
            if (drop) m_ovf = 1'b1;
            else if (oc) m_ovf = 1'b0;
        end
        m_irq = ((thr != 0) && (mq.size() >= int'(thr))) || m_ovf;
    endtask

    task automatic cyc(input bit c, input logic [DW-1:0] v, input bit p,
                       input bit cl = 1'b0, input bit oc = 1'b0);
        @(posedge clk);
        #2;
        cap  = c;
        val  = v;
        pop  = p;
        clr  = cl;
        oclr = oc;
        thr  = thr_next;
        model_step(c, v, p, cl, oc);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_level"}, level, 0);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_full"}, full, 0);
        check({tag, "_ovf"}, ovf, 0);
        check({tag, "_irq"}, irq, 0);
        check({tag, "_data"}, pop_data, 0);
        check({tag, "_seq"}, pop_seq, 0);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        cap = 1'b0; pop = 1'b0; clr = 1'b0; oclr = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        mq.delete();
        m_seq = '0;
        m_ovf = 1'b0;
        m_irq = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Status monitor: state just after each edge against the model.
    always @(posedge clk) begin
        #1;
        if (chk_on) begin
            check("level", level, mq.size());
            check("empty", empty, mq.size() == 0);
            check("full", full, mq.size() == DEPTH);
            check("ovf", ovf, m_ovf);
            check("irq", irq, m_irq);
            if (mq.size() > 0) begin
                check("head_data", pop_data, mq[0].val);
                check("head_seq", pop_seq, mq[0].seq);
            end else begin
                check("empty_data", pop_data, 0);
                check("empty_seq", pop_seq, 0);
            end
        end
    end

    // Pop monitor: every entry the DUT hands out is matched against the scoreboard.
    always @(negedge clk) begin
        if (chk_on && rst_n && pop && !clr && !empty) begin
            if (exp_pop.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pop_unexpected: got data 0x%0h seq %0d expected no entry", pop_data, pop_seq);
            end else begin
                mon_e = exp_pop.pop_front();
                check("pop_data", pop_data, mon_e.val);
                check("pop_seq", pop_seq, mon_e.seq);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        rst_n  = 1'b1;
        chk_on = 1'b1;

        // 1: basic ordering
        cyc(1, 32'h10, 0); cyc(1, 32'h20, 0); cyc(1, 32'h30, 0);
        cyc(0, 0, 0);
        check("t1_level3", level, 3);
        repeat (3) cyc(0, 0, 1);
        cyc(0, 0, 0);
        check("t1_empty", empty, 1);
        check("t1_data0", pop_data, 0);

        // 2: overflow and sequence gap
        cyc(0, 0, 0, 1);
        repeat (10) cyc(1, $urandom, 0);
        cyc(0, 0, 0);
        check("t2_full", full, 1);
        check("t2_ovf", ovf, 1);
        check("t2_level8", level, 8);
        repeat (8) cyc(0, 0, 1);
        cyc(1, 32'hABCD, 0);
        cyc(0, 0, 0);
        check("t2_gap_seq", pop_seq, 10);
        cyc(0, 0, 1);

        // 3: simultaneous push/pop at full and at empty
        cyc(0, 0, 0, 1);
        repeat (8) cyc(1, $urandom, 0);
        cyc(1, 32'h55, 1);
        cyc(0, 0, 0);
        check("t3_level_full", level, 8);
        check("t3_no_ovf", ovf, 0);
        repeat (8) cyc(0, 0, 1);
        cyc(1, 32'h66, 1);
        cyc(0, 0, 0);
        check("t3_level1", level, 1);
        cyc(0, 0, 1);

        // 4: level threshold
        cyc(0, 0, 0, 1);
        thr_next = 4;
        repeat (3) cyc(1, $urandom, 0);
        cyc(0, 0, 0);
        check("t4_irq_below", irq, 0);
        cyc(1, $urandom, 0);
        cyc(0, 0, 0);
        check("t4_irq_at", irq, 1);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        check("t4_irq_after_pop", irq, 0);
        thr_next = 0;
        cyc(0, 0, 0, 1);
        repeat (9) cyc(1, $urandom, 0);
        cyc(0, 0, 0);
        check("t4_irq_ovf", irq, 1);

        // 5: ovf clear vs set
        cyc(1, $urandom, 0, 0, 1);
        cyc(0, 0, 0);
        check("t5_set_wins", ovf, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0);
        check("t5_ovf_clr", ovf, 0);
        check("t5_irq_clr", irq, 0);

        // 6: flush with strobe, then async reset mid-burst
        cyc(0, 0, 0, 1);
        repeat (5) cyc(1, $urandom, 0);
        cyc(1, $urandom, 0, 1);
        cyc(0, 0, 0);
        check("t6_level0", level, 0);
        check("t6_empty", empty, 1);
        check("t6_ovf0", ovf, 0);
        cyc(1, 32'h77, 0);
        cyc(0, 0, 0);
        check("t6_seq0", pop_seq, 0);
        repeat (4) cyc(1, $urandom, 0);
        async_reset();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) thr_next = LW'($urandom_range(0, 10));
            if ($urandom_range(0, 499) == 0) begin
                async_reset();
            end else begin
                cyc($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 45,
                    $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5);
            end
        end
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        check("scoreboard_drained", exp_pop.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
